// File: rtl/logic_bist_engine.sv
// logic_bist_engine: BIST engine for the 16-bit bitwise logic unit.
// Two Fibonacci LFSRs generate operand pairs, a MISR compresses the returned
// results, and the final signature is compared against a golden value.
// Optional feature macro: LOGIC_BIST_ABORT_EN adds an `abort` input that
// cancels a run in progress and returns the engine to IDLE.
module logic_bist_engine #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned PATTERNS = 64,
  parameter logic [15:0] SEED_A   = 16'hACE1,
  parameter logic [15:0] SEED_B   = 16'h1D0F
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef LOGIC_BIST_ABORT_EN
  input  logic             abort,
`endif
  input  logic [WIDTH-1:0] golden,
  input  logic [WIDTH-1:0] dut_y,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature
);

  typedef enum logic [1:0] {StIdle, StRun, StCompare, StDone} state_e;

  localparam logic [15:0] LastCnt = 16'(PATTERNS - 1);

  // Shared feedback polynomial for both LFSRs and the MISR (taps 15,13,12,10).
  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] misr_q, misr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        abort_req;

`ifdef LOGIC_BIST_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Next-state and registered-output computation for the run sequencer.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          a_d     = SEED_A;
          b_d     = SEED_B;
          misr_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      StRun: begin
        if (abort_req) begin
          // Partial signature and operands are kept for debug visibility.
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end else begin
          misr_d = lfsr_next(misr_q) ^ dut_y[15:0];
          a_d    = lfsr_next(a_q);
          b_d    = lfsr_next(b_q);
          cnt_d  = cnt_q + 16'd1;
          if (cnt_q == LastCnt) begin
            state_d = StCompare;
          end
        end
      end
      StCompare: begin
        busy_d  = 1'b0;
        if (abort_req) begin
          state_d = StIdle;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end else begin
          state_d = StDone;
          done_d  = 1'b1;
          pass_d  = (misr_q == golden[15:0]);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      misr_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign dut_a     = a_q;
  assign dut_b     = b_q;
  assign signature = misr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_logic_bist_engine.sv
// Testbench for logic_bist_engine: a PATTERNS=1 instance with hand-computed
// vectors and a PATTERNS=64 instance checked against a bench-side model.
module tb_logic_bist_engine;

  logic        clk;
  logic        rst_n;
  int          checks;
  int          errors;

  logic        start1, busy1, done1, pass1;
  logic [15:0] golden1, a1, b1, y1, sig1;
  logic        start64, busy64, done64, pass64;
  logic [15:0] golden64, a64, b64, y64, sig64;
  logic [15:0] fault_mask;
  logic        abort1, abort64;

  // Device under test is a 16-bit OR; fault_mask forces result bits to 0.
  assign y1  = a1 | b1;
  assign y64 = (a64 | b64) & ~fault_mask;

  logic_bist_engine #(.WIDTH(16), .PATTERNS(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start1),
`ifdef LOGIC_BIST_ABORT_EN
    .abort     (abort1),
`endif
    .golden    (golden1),
    .dut_y     (y1),
    .dut_a     (a1),
    .dut_b     (b1),
    .busy      (busy1),
    .done      (done1),
    .pass      (pass1),
    .signature (sig1)
  );

  logic_bist_engine #(.WIDTH(16), .PATTERNS(64)) u_dut64 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start64),
`ifdef LOGIC_BIST_ABORT_EN
    .abort     (abort64),
`endif
    .golden    (golden64),
    .dut_y     (y64),
    .dut_a     (a64),
    .dut_b     (b64),
    .busy      (busy64),
    .done      (done64),
    .pass      (pass64),
    .signature (sig64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] adv(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  function automatic logic [15:0] adv_n(input logic [15:0] x, input int n);
    logic [15:0] v;
    v = x;
    for (int i = 0; i < n; i++) v = adv(v);
    return v;
  endfunction

  // Reference signature after n patterns of the OR unit with a stuck-at-0 mask.
  function automatic logic [15:0] model_sig(input int n, input logic [15:0] mask);
    logic [15:0] a, b, m;
    a = 16'hACE1;
    b = 16'h1D0F;
    m = '0;
    for (int i = 0; i < n; i++) begin
      m = adv(m) ^ ((a | b) & ~mask);
      a = adv(a);
      b = adv(b);
    end
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulses start64 and counts sampled busy cycles until busy drops (bounded).
  task automatic run64(input int mid_start_at, output int nbusy);
    int guard;
    start64 = 1'b1;
    step();
    start64 = 1'b0;
    nbusy = 0;
    guard = 0;
    while (busy64 && guard < 200) begin
      nbusy++;
      start64 = (guard == mid_start_at);
      step();
      start64 = 1'b0;
      guard++;
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    start1  = 1'b1;
    start64 = 1'b1;
    repeat (3) step();
    checks++;
    if ({a1, b1, sig1, busy1, done1, pass1} !== 51'd0) begin
      errors++;
      $display("FAIL reset_dut1 got %h exp 0", {a1, b1, sig1, busy1, done1, pass1});
    end
    checks++;
    if ({a64, b64, sig64, busy64, done64, pass64} !== 51'd0) begin
      errors++;
      $display("FAIL reset_dut64 got %h exp 0", {a64, b64, sig64, busy64, done64, pass64});
    end
    start1  = 1'b0;
    start64 = 1'b0;
    rst_n   = 1'b1;
    repeat (5) step();
    checks++;
    if ({a1, b1, sig1, busy1, done1, pass1} !== 51'd0) begin
      errors++;
      $display("FAIL idle_dut1 got %h exp 0", {a1, b1, sig1, busy1, done1, pass1});
    end
    checks++;
    if ({a64, b64, sig64, busy64, done64, pass64} !== 51'd0) begin
      errors++;
      $display("FAIL idle_dut64 got %h exp 0", {a64, b64, sig64, busy64, done64, pass64});
    end
  endtask

  task automatic test_single_pass();
    golden1 = 16'hBDEF;
    start1  = 1'b1;
    step();
    start1  = 1'b0;
    checks++;
    if ({a1, b1} !== {16'hACE1, 16'h1D0F}) begin
      errors++;
      $display("FAIL first_pair got %h exp %h", {a1, b1}, {16'hACE1, 16'h1D0F});
    end
    checks++;
    if ({busy1, done1} !== 2'b10) begin
      errors++;
      $display("FAIL busy_after_start got %b exp 10", {busy1, done1});
    end
    step();
    checks++;
    if ({busy1, done1, sig1} !== {2'b10, 16'hBDEF}) begin
      errors++;
      $display("FAIL run_edge1 got %h exp %h", {busy1, done1, sig1}, {2'b10, 16'hBDEF});
    end
    step();
    checks++;
    if ({busy1, done1, pass1} !== 3'b011) begin
      errors++;
      $display("FAIL single_done got %b exp 011", {busy1, done1, pass1});
    end
    checks++;
    if (sig1 !== 16'hBDEF) begin
      errors++;
      $display("FAIL single_sig got %h exp bdef", sig1);
    end
    checks++;
    if (a1 !== 16'h59C3) begin
      errors++;
      $display("FAIL second_a got %h exp 59c3", a1);
    end
  endtask

  task automatic test_single_fail();
    golden1 = 16'hBDEE;
    start1  = 1'b1;
    step();
    start1  = 1'b0;
    checks++;
    if ({busy1, done1, pass1} !== 3'b100) begin
      errors++;
      $display("FAIL restart_from_done got %b exp 100", {busy1, done1, pass1});
    end
    repeat (2) step();
    checks++;
    if ({done1, pass1, sig1} !== {2'b10, 16'hBDEF}) begin
      errors++;
      $display("FAIL single_fail got %h exp %h", {done1, pass1, sig1}, {2'b10, 16'hBDEF});
    end
    checks++;
    if (a1 !== 16'h59C3) begin
      errors++;
      $display("FAIL second_a_rerun got %h exp 59c3", a1);
    end
  endtask

  task automatic test_full_run();
    int nbusy;
    fault_mask = '0;
    golden64   = model_sig(64, 16'h0000);
    run64(-1, nbusy);
    checks++;
    if (nbusy !== 65) begin
      errors++;
      $display("FAIL busy_cycles got %0d exp 65", nbusy);
    end
    checks++;
    if ({done64, pass64, sig64} !== {2'b11, golden64}) begin
      errors++;
      $display("FAIL full_pass got %h exp %h", {done64, pass64, sig64}, {2'b11, golden64});
    end
    checks++;
    if ({a64, b64} !== {adv_n(16'hACE1, 64), adv_n(16'h1D0F, 64)}) begin
      errors++;
      $display("FAIL final_operands got %h exp %h", {a64, b64},
               {adv_n(16'hACE1, 64), adv_n(16'h1D0F, 64)});
    end
    // DONE holds its outputs.
    repeat (3) step();
    checks++;
    if ({busy64, done64, pass64, sig64} !== {3'b011, golden64}) begin
      errors++;
      $display("FAIL done_hold got %h exp %h", {busy64, done64, pass64, sig64},
               {3'b011, golden64});
    end
  endtask

  task automatic test_stuck_fault();
    int nbusy;
    logic [15:0] bad;
    fault_mask = 16'h0008;
    bad = model_sig(64, 16'h0008);
    run64(-1, nbusy);
    checks++;
    if ({done64, pass64, sig64} !== {1'b1, bad == golden64, bad}) begin
      errors++;
      $display("FAIL stuck_fault got %h exp %h", {done64, pass64, sig64},
               {1'b1, bad == golden64, bad});
    end
    checks++;
    if (pass64 !== 1'b0) begin
      errors++;
      $display("FAIL stuck_fault_pass got %b exp 0", pass64);
    end
    fault_mask = '0;
  endtask

  task automatic test_start_mid_run();
    int nbusy;
    run64(10, nbusy);
    checks++;
    if (nbusy !== 65) begin
      errors++;
      $display("FAIL mid_start_busy got %0d exp 65", nbusy);
    end
    checks++;
    if ({done64, pass64, sig64} !== {2'b11, golden64}) begin
      errors++;
      $display("FAIL mid_start_result got %h exp %h", {done64, pass64, sig64}, {2'b11, golden64});
    end
  endtask

  task automatic test_start_in_done();
    int guard;
    start64 = 1'b1;
    checks++;
    if (done64 !== 1'b1) begin
      errors++;
      $display("FAIL pre_done got %b exp 1", done64);
    end
    step();
    start64 = 1'b0;
    checks++;
    if ({busy64, done64, pass64, a64, sig64} !== {3'b100, 16'hACE1, 16'h0000}) begin
      errors++;
      $display("FAIL done_restart got %h exp %h", {busy64, done64, pass64, a64, sig64},
               {3'b100, 16'hACE1, 16'h0000});
    end
    guard = 0;
    while (!done64 && guard < 200) begin
      step();
      guard++;
    end
    checks++;
    if ({guard, done64, pass64} !== {32'd65, 2'b11}) begin
      errors++;
      $display("FAIL done_restart_finish got edges=%0d done=%b pass=%b exp 65 1 1",
               guard, done64, pass64);
    end
  endtask

  task automatic test_reset_mid_run();
    start64 = 1'b1;
    step();
    start64 = 1'b0;
    repeat (10) step();
    rst_n = 1'b0;
    step();
    checks++;
    if ({a64, b64, sig64, busy64, done64, pass64} !== 51'd0) begin
      errors++;
      $display("FAIL reset_mid_run got %h exp 0", {a64, b64, sig64, busy64, done64, pass64});
    end
    rst_n = 1'b1;
    step();
  endtask

`ifdef LOGIC_BIST_ABORT_EN
  task automatic test_abort();
    int nbusy;
    start64 = 1'b1;
    step();
    start64 = 1'b0;
    repeat (20) step();
    abort64 = 1'b1;
    step();
    abort64 = 1'b0;
    checks++;
    if ({busy64, done64, pass64, sig64} !== {3'b000, model_sig(20, 16'h0000)}) begin
      errors++;
      $display("FAIL abort_state got %h exp %h", {busy64, done64, pass64, sig64},
               {3'b000, model_sig(20, 16'h0000)});
    end
    checks++;
    if (a64 !== adv_n(16'hACE1, 20)) begin
      errors++;
      $display("FAIL abort_a_hold got %h exp %h", a64, adv_n(16'hACE1, 20));
    end
    step();
    checks++;
    if (busy64 !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got %b exp 0", busy64);
    end
    run64(-1, nbusy);
    checks++;
    if ({nbusy, done64, pass64, sig64} !== {32'd65, 2'b11, golden64}) begin
      errors++;
      $display("FAIL abort_rerun got busy=%0d done=%b pass=%b sig=%h exp 65 1 1 %h",
               nbusy, done64, pass64, sig64, golden64);
    end
  endtask
`endif

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    start1     = 1'b0;
    start64    = 1'b0;
    golden1    = '0;
    golden64   = '0;
    fault_mask = '0;
    abort1     = 1'b0;
    abort64    = 1'b0;
    test_reset();
    test_single_pass();
    test_single_fail();
    test_full_run();
    test_stuck_fault();
    test_start_mid_run();
    test_start_in_done();
    test_reset_mid_run();
`ifdef LOGIC_BIST_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_bist_engine.md
# logic_bist_engine

Built-in self-test engine for the 16-bit bitwise logic unit (OR/AND/XOR/NOT datapaths). It generates pseudo-random operand pairs on its outputs and drives them into the unit under test. It compresses every result word into a multiple-input signature register (MISR) and compares the final signature against a golden value. It sits beside the ALU logic slice and runs under test-controller command.

## Interface
- `WIDTH`, 16: operand/result width; only 16 is supported.
- `PATTERNS`, 64: number of operand pairs applied per run; legal range 1..65535.
- `SEED_A`, 16'hACE1: operand-A LFSR seed; must be nonzero.
- `SEED_B`, 16'h1D0F: operand-B LFSR seed; must be nonzero.

- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `start`  in  1: run request, sampled high for one cycle.
- `golden`  in  16: expected final signature; sampled in COMPARE.
- `dut_y`  in  16: result from the logic unit. Combinational response to `dut_a`/`dut_b`.
- `dut_a`  out  16: operand A, registered.
- `dut_b`  out  16: operand B, registered.
- `busy`  out  1: high in RUN and COMPARE.
- `done`  out  1: high in DONE; held until the next accepted start or reset.
- `pass`  out  1: valid when `done`=1; 1 means the signature matched `golden`.
- `signature`  out  16: current MISR contents.

## Operation
- States:
  - IDLE: reset state.
  - RUN: applies patterns.
  - COMPARE: one cycle.
  - DONE: result held.
- Accepting `start`:
  - Accepted in IDLE or DONE only; ignored in RUN and COMPARE.
  - On acceptance: `dut_a`←SEED_A, `dut_b`←SEED_B, MISR←0, pattern count←0, `done`←0, `pass`←0. State→RUN.
- Each RUN edge:
  - MISR ← {m[14:0], fbm} ^ `dut_y`, where fbm = m[15]^m[13]^m[12]^m[10].
  - Each LFSR (Fibonacci) advances: x ← {x[14:0], x[15]^x[13]^x[12]^x[10]}.
  - Count increments.
  - When count == PATTERNS-1 at the edge, state→COMPARE.
- COMPARE: `pass` ← (MISR == `golden`), `done` ← 1, state→DONE. MISR is not updated.
- DONE: all outputs hold. `dut_a`/`dut_b` hold their last-applied values advanced once.
- Count width is 16 bits. LFSRs never reach zero with nonzero seeds; behaviour with a zero seed is undefined.

## Timing
- Reset values: `dut_a`=0, `dut_b`=0, `busy`=0, `done`=0, `pass`=0, `signature`=0, state=IDLE.
- Edge-by-edge from the edge sampling `start`=1:
  - Edge 0 accepts `start`.
  - Edges 1..PATTERNS capture `dut_y` for patterns 1..PATTERNS.
  - Edge PATTERNS+1 (COMPARE) sets `done` and `pass`.
- Total latency from the `start` edge to `done` high is PATTERNS+1 edges. `busy` is high for exactly PATTERNS+1 cycles.
- `dut_y` must settle within one cycle of a `dut_a`/`dut_b` change; the engine samples it at the next rising edge.
- `golden` must be stable in the COMPARE cycle.
- `start` asserted in the same cycle `done` is high: the start is accepted, and `done` drops on the next edge.
- `rst_n` low mid-run: all outputs return to reset values on that edge. No partial result is retained.

## Configuration
- `LOGIC_BIST_ABORT_EN` defined:
  - Adds input `abort` (1 bit).
  - `abort`=1 in RUN or COMPARE forces state→IDLE on that edge, with `busy`=0, `done`=0, `pass`=0.
  - `signature` holds its partial value; `dut_a`/`dut_b` hold.
  - `abort` has priority over the RUN→COMPARE transition. It is ignored in IDLE and DONE.
- `LOGIC_BIST_ABORT_EN` undefined: no `abort` port; a run always completes.

## Test plan
- Reset, then idle 5 cycles → all outputs 0, state IDLE. `start` during `rst_n`=0 is ignored.
- PATTERNS=1, DUT=16-bit OR, `golden`=16'hBDEF, pulse `start` → first applied pair is `dut_a`=16'hACE1, `dut_b`=16'h1D0F. `done`=1 two edges after start, `pass`=1, `signature`=16'hBDEF.
- Same run with `golden`=16'hBDEE → `done`=1, `pass`=0, `signature`=16'hBDEF. Second applied `dut_a`=16'h59C3.
- PATTERNS=64, OR DUT, `golden` from the reference model → `busy` high exactly 65 cycles, then `pass`=1. Inject a stuck-at-0 on `dut_y[3]` → `pass`=0.
- Pulse `start` at mid-run cycle 10 → ignored, completion timing unchanged. Pulse `start` while in DONE → a new run starts and `done` clears next edge.
- With `LOGIC_BIST_ABORT_EN`, assert `abort` at RUN cycle 20 → IDLE next edge, `busy`=0, `done`=0. A following `start` runs a full clean pass.
